// File: rtl/hazard_tracker.sv
// hazard_tracker
// Pipeline hazard unit for a five-stage in-order core. Tracks the destination
// register and remaining result latency (Tnew) of instructions in E, M and W,
// compares them against the operand needs (Tuse) of the instruction in D,
// and produces a stall request plus bypass selects for the D, E and M operands.
//
// Build option: define HAZARD_FWD_EN to enable bypassing. Without it every
// fwd_* output is 0 and any pending write to a register that D reads stalls.
//
// Ports
//   clk                 pipeline clock, rising edge
//   reset               synchronous active-high reset
//   d_a1, d_a2          D-stage rs / rt read addresses (0 = no read)
//   d_a3                D-stage destination (0 = no write)
//   d_ic                D-stage hazard class (10-15 behave as nop)
//   stall               freeze PC and IF/ID, bubble into E
//   fwd_d_rs, fwd_d_rt  D bypass: 0=RF 1=E 2=M 3=W
//   fwd_e_rs, fwd_e_rt  E bypass: 0=pipeline reg 2=M 3=W
//   fwd_m_rt            M store-data bypass: 0=pipeline reg 3=W
module hazard_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_a1,
  input  logic [4:0] d_a2,
  input  logic [4:0] d_a3,
  input  logic [3:0] d_ic,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic [1:0] fwd_m_rt
);

  localparam logic [3:0] CLS_CAL_R = 4'd1;
  localparam logic [3:0] CLS_CAL_I = 4'd2;
  localparam logic [3:0] CLS_LOAD  = 4'd3;
  localparam logic [3:0] CLS_STORE = 4'd4;
  localparam logic [3:0] CLS_B     = 4'd5;
  localparam logic [3:0] CLS_JR    = 4'd7;
  localparam logic [3:0] CLS_JAL   = 4'd8;
  localparam logic [3:0] CLS_JALR  = 4'd9;

  // Class decode: when an operand is read and when a result becomes ready.
  logic       tuse_rs_vld, tuse_rt_vld, tnew_vld;
  logic [1:0] tuse_rs, tuse_rt, tnew_dec;

  always_comb begin
    tuse_rs_vld = 1'b0;
    tuse_rs     = 2'd0;
    tuse_rt_vld = 1'b0;
    tuse_rt     = 2'd0;
    tnew_vld    = 1'b0;
    tnew_dec    = 2'd0;
    case (d_ic)
      CLS_CAL_R: begin
        tuse_rs_vld = 1'b1; tuse_rs = 2'd1;
        tuse_rt_vld = 1'b1; tuse_rt = 2'd1;
        tnew_vld    = 1'b1; tnew_dec = 2'd1;
      end
      CLS_CAL_I: begin
        tuse_rs_vld = 1'b1; tuse_rs = 2'd1;
        tnew_vld    = 1'b1; tnew_dec = 2'd1;
      end
      CLS_LOAD: begin
        tuse_rs_vld = 1'b1; tuse_rs = 2'd1;
        tnew_vld    = 1'b1; tnew_dec = 2'd2;
      end
      CLS_STORE: begin
        tuse_rs_vld = 1'b1; tuse_rs = 2'd1;
        tuse_rt_vld = 1'b1; tuse_rt = 2'd2;
      end
      CLS_B: begin
        tuse_rs_vld = 1'b1; tuse_rs = 2'd0;
        tuse_rt_vld = 1'b1; tuse_rt = 2'd0;
      end
      CLS_JR: begin
        tuse_rs_vld = 1'b1; tuse_rs = 2'd0;
      end
      CLS_JAL: begin
        tnew_vld    = 1'b1; tnew_dec = 2'd0;
      end
      CLS_JALR: begin
        tuse_rs_vld = 1'b1; tuse_rs = 2'd0;
        tnew_vld    = 1'b1; tnew_dec = 2'd0;
      end
      default: ;
    endcase
  end

  // Pipeline tracking state. W only needs its destination: its result is
  // always ready.
  logic [4:0] e_a1_q, e_a2_q, e_a3_q, m_a2_q, m_a3_q, w_a3_q;
  logic [1:0] e_tnew_q, m_tnew_q;
  logic [4:0] e_a1_d, e_a2_d, e_a3_d;
  logic [1:0] e_tnew_d, m_tnew_d;

  always_comb begin
    e_a1_d   = d_a1;
    e_a2_d   = d_a2;
    // A class that never writes enters E with no destination so it can
    // never be matched downstream.
    e_a3_d   = tnew_vld ? d_a3 : 5'd0;
    e_tnew_d = tnew_vld ? tnew_dec : 2'd0;
    if (stall) begin
      e_a1_d   = 5'd0;
      e_a2_d   = 5'd0;
      e_a3_d   = 5'd0;
      e_tnew_d = 2'd0;
    end
    m_tnew_d = (e_tnew_q != 2'd0) ? e_tnew_q - 2'd1 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a1_q   <= 5'd0;
      e_a2_q   <= 5'd0;
      e_a3_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      m_a2_q   <= 5'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      w_a3_q   <= 5'd0;
    end else begin
      e_a1_q   <= e_a1_d;
      e_a2_q   <= e_a2_d;
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_a2_q   <= e_a2_q;
      m_a3_q   <= e_a3_q;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= m_a3_q;
    end
  end

  // Address hits against D operands. A zero a3 never hits, which also keeps
  // a zero read address from ever matching.
  logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
  assign e_hit_rs = (e_a3_q != 5'd0) && (e_a3_q == d_a1);
  assign e_hit_rt = (e_a3_q != 5'd0) && (e_a3_q == d_a2);
  assign m_hit_rs = (m_a3_q != 5'd0) && (m_a3_q == d_a1);
  assign m_hit_rt = (m_a3_q != 5'd0) && (m_a3_q == d_a2);

`ifdef HAZARD_FWD_EN
  // Stall only when the producer cannot deliver by the time D needs it.
  assign stall = (e_hit_rs && tuse_rs_vld && (e_tnew_q > tuse_rs)) ||
                 (e_hit_rt && tuse_rt_vld && (e_tnew_q > tuse_rt)) ||
                 (m_hit_rs && tuse_rs_vld && (m_tnew_q > tuse_rs)) ||
                 (m_hit_rt && tuse_rt_vld && (m_tnew_q > tuse_rt));

  // Nearest ready producer wins.
  always_comb begin
    fwd_d_rs = 2'd0;
    fwd_d_rt = 2'd0;
    fwd_e_rs = 2'd0;
    fwd_e_rt = 2'd0;
    fwd_m_rt = 2'd0;

    if (e_hit_rs && (e_tnew_q == 2'd0))      fwd_d_rs = 2'd1;
    else if (m_hit_rs && (m_tnew_q == 2'd0)) fwd_d_rs = 2'd2;

    if (e_hit_rt && (e_tnew_q == 2'd0))      fwd_d_rt = 2'd1;
    else if (m_hit_rt && (m_tnew_q == 2'd0)) fwd_d_rt = 2'd2;

    if ((m_a3_q != 5'd0) && (m_a3_q == e_a1_q) && (m_tnew_q == 2'd0)) fwd_e_rs = 2'd2;
    else if ((w_a3_q != 5'd0) && (w_a3_q == e_a1_q))                  fwd_e_rs = 2'd3;

    if ((m_a3_q != 5'd0) && (m_a3_q == e_a2_q) && (m_tnew_q == 2'd0)) fwd_e_rt = 2'd2;
    else if ((w_a3_q != 5'd0) && (w_a3_q == e_a2_q))                  fwd_e_rt = 2'd3;

    if ((w_a3_q != 5'd0) && (w_a3_q == m_a2_q)) fwd_m_rt = 2'd3;
  end
`else
  // No bypass network: any in-flight write to an operand D actually reads
  // holds D until the value has reached the register file.
  assign stall = ((e_hit_rs || m_hit_rs) && tuse_rs_vld) ||
                 ((e_hit_rt || m_hit_rt) && tuse_rt_vld);

  assign fwd_d_rs = 2'd0;
  assign fwd_d_rt = 2'd0;
  assign fwd_e_rs = 2'd0;
  assign fwd_e_rt = 2'd0;
  assign fwd_m_rt = 2'd0;

  // Timing and operand state is only consumed by the bypass build; fold it
  // here so this build carries no dangling nets.
  logic unused_nofwd;
  assign unused_nofwd = ^{e_a1_q, e_a2_q, m_a2_q, e_tnew_q, m_tnew_q,
                          tuse_rs, tuse_rt, w_a3_q};
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
module tb_hazard_tracker;

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_a1, d_a2, d_a3;
  logic [3:0] d_ic;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

  hazard_tracker dut (
    .clk      (clk),
    .reset    (reset),
    .d_a1     (d_a1),
    .d_a2     (d_a2),
    .d_a3     (d_a3),
    .d_ic     (d_ic),
    .stall    (stall),
    .fwd_d_rs (fwd_d_rs),
    .fwd_d_rt (fwd_d_rt),
    .fwd_e_rs (fwd_e_rs),
    .fwd_e_rt (fwd_e_rt),
    .fwd_m_rt (fwd_m_rt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the three in-flight instructions indexed by age since
  // entering E (0=E, 1=M, 2=W). Remaining latency is issue Tnew minus age.
  int sl_a1[3], sl_a2[3], sl_a3[3], sl_tn[3];
  logic [7:0] e_stall, e_fdrs, e_fdrt, e_fers, e_fert, e_fmrt;
  logic [7:0] o_stall, o_fdrs, o_fdrt, o_fers, o_fert, o_fmrt;

  localparam int NONE = 99;

  function automatic int tuse_rs_f(int ic);
    case (ic)
      5, 7, 9:    return 0;
      1, 2, 3, 4: return 1;
      default:    return NONE;
    endcase
  endfunction

  function automatic int tuse_rt_f(int ic);
    case (ic)
      5:       return 0;
      1:       return 1;
      4:       return 2;
      default: return NONE;
    endcase
  endfunction

  function automatic int tnew_f(int ic);
    case (ic)
      3:       return 2;
      1, 2:    return 1;
      8, 9:    return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int rem(int age);
    return (sl_tn[age] - age > 0) ? sl_tn[age] - age : 0;
  endfunction

  // Age of the nearest ready producer of addr in ages lo..hi, or -1.
  function automatic int near(int addr, int lo, int hi);
    for (int a = lo; a <= hi; a++)
      if (sl_a3[a] != 0 && sl_a3[a] == addr && rem(a) == 0) return a;
    return -1;
  endfunction

  function automatic logic [7:0] sel(int age);
    return (!FWD_EN || age < 0) ? 8'd0 : 8'(age + 1);
  endfunction

  task automatic model_eval();
    int tr, tt, s;
    tr = tuse_rs_f(int'(d_ic));
    tt = tuse_rt_f(int'(d_ic));
    s  = 0;
    for (int a = 0; a < 2; a++) begin
      if (sl_a3[a] != 0 && sl_a3[a] == int'(d_a1))
        if (FWD_EN ? (rem(a) > tr) : (tr != NONE)) s = 1;
      if (sl_a3[a] != 0 && sl_a3[a] == int'(d_a2))
        if (FWD_EN ? (rem(a) > tt) : (tt != NONE)) s = 1;
    end
    e_stall = 8'(s);
    e_fdrs  = sel(near(int'(d_a1), 0, 1));
    e_fdrt  = sel(near(int'(d_a2), 0, 1));
    e_fers  = sel(near(sl_a1[0], 1, 2));
    e_fert  = sel(near(sl_a2[0], 1, 2));
    e_fmrt  = sel(near(sl_a2[1], 2, 2));
  endtask

  task automatic model_adv(input bit rst);
    int tn;
    if (rst) begin
      for (int a = 0; a < 3; a++) begin
        sl_a1[a] = 0; sl_a2[a] = 0; sl_a3[a] = 0; sl_tn[a] = 0;
      end
    end else begin
      for (int a = 2; a > 0; a--) begin
        sl_a1[a] = sl_a1[a-1]; sl_a2[a] = sl_a2[a-1];
        sl_a3[a] = sl_a3[a-1]; sl_tn[a] = sl_tn[a-1];
      end
      tn = tnew_f(int'(d_ic));
      if (e_stall != 0) begin
        sl_a1[0] = 0; sl_a2[0] = 0; sl_a3[0] = 0; sl_tn[0] = 0;
      end else begin
        sl_a1[0] = int'(d_a1);
        sl_a2[0] = int'(d_a2);
        sl_a3[0] = (tn < 0) ? 0 : int'(d_a3);
        sl_tn[0] = (tn < 0) ? 0 : tn;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive D and reset, compare all outputs against the
  // model mid-cycle, then advance both DUT and model on the rising edge.
  task automatic cycle(input bit rst, input logic [3:0] ic, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3, input string tag);
    reset = rst; d_ic = ic; d_a1 = a1; d_a2 = a2; d_a3 = a3;
    @(negedge clk);
    model_eval();
    o_stall = 8'(stall);
    o_fdrs = 8'(fwd_d_rs); o_fdrt = 8'(fwd_d_rt);
    o_fers = 8'(fwd_e_rs); o_fert = 8'(fwd_e_rt); o_fmrt = 8'(fwd_m_rt);
    check({tag, "/stall"},    o_stall, e_stall);
    check({tag, "/fwd_d_rs"}, o_fdrs,  e_fdrs);
    check({tag, "/fwd_d_rt"}, o_fdrt,  e_fdrt);
    check({tag, "/fwd_e_rs"}, o_fers,  e_fers);
    check({tag, "/fwd_e_rt"}, o_fert,  e_fert);
    check({tag, "/fwd_m_rt"}, o_fmrt,  e_fmrt);
    @(posedge clk);
    model_adv(rst);
    #1;
  endtask

  task automatic nop(input string tag);
    cycle(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, tag);
  endtask

  initial begin
    logic [3:0] ric;
    logic [4:0] ra1, ra2, ra3;
    bit         rrst;

    for (int a = 0; a < 3; a++) begin
      sl_a1[a] = 0; sl_a2[a] = 0; sl_a3[a] = 0; sl_tn[a] = 0;
    end
    e_stall = 8'd0;
    reset = 1'b1; d_ic = 4'd0; d_a1 = 5'd0; d_a2 = 5'd0; d_a3 = 5'd0;
    @(posedge clk); #1;
    cycle(1'b1, 4'd0, 5'd0, 5'd0, 5'd0, "rst");
    nop("post_rst");
    check("post_rst_stall_const", o_stall, 8'd0);

    // addu $3 then addu reading $3
    cycle(1'b0, 4'd1, 5'd1, 5'd2, 5'd3, "alu_p");
    cycle(1'b0, 4'd1, 5'd3, 5'd0, 5'd8, "alu_c");
    if (FWD_EN) check("alu_c_stall_const", o_stall, 8'd0);
    nop("alu_e");
    if (FWD_EN) check("alu_e_fwd_e_rs_const", o_fers, 8'd2);
    nop("alu_f1"); nop("alu_f2");

    // lw $5 then addu reading $5 via rt
    cycle(1'b0, 4'd3, 5'd1, 5'd0, 5'd5, "lw_p");
    cycle(1'b0, 4'd1, 5'd2, 5'd5, 5'd7, "lw_c1");
    check("lw_c1_stall_const", o_stall, 8'd1);
    cycle(1'b0, 4'd1, 5'd2, 5'd5, 5'd7, "lw_c2");
    check("lw_c2_stall_const", o_stall, FWD_EN ? 8'd0 : 8'd1);
    if (FWD_EN) begin
      nop("lw_e");
      check("lw_e_fwd_e_rt_const", o_fert, 8'd3);
    end else begin
      cycle(1'b0, 4'd1, 5'd2, 5'd5, 5'd7, "lw_c3");
      check("lw_c3_stall_const", o_stall, 8'd0);
      nop("lw_e");
      check("lw_e_fwd_e_rt_const", o_fert, 8'd0);
    end
    nop("lw_f1"); nop("lw_f2");

    // addu $4 then beq on $4
    cycle(1'b0, 4'd1, 5'd1, 5'd2, 5'd4, "br_p");
    cycle(1'b0, 4'd5, 5'd4, 5'd0, 5'd0, "br_c1");
    check("br_c1_stall_const", o_stall, 8'd1);
    cycle(1'b0, 4'd5, 5'd4, 5'd0, 5'd0, "br_c2");
    if (FWD_EN) check("br_c2_fwd_d_rs_const", o_fdrs, 8'd2);
    nop("br_f1"); nop("br_f2"); nop("br_f3");

    // jal then jr $31
    cycle(1'b0, 4'd8, 5'd0, 5'd0, 5'd31, "jal_p");
    cycle(1'b0, 4'd7, 5'd31, 5'd0, 5'd0, "jr_c");
    if (FWD_EN) check("jr_c_fwd_d_rs_const", o_fdrs, 8'd1);
    nop("jr_f1"); nop("jr_f2"); nop("jr_f3");

    // lw $6 then sw storing $6
    cycle(1'b0, 4'd3, 5'd1, 5'd0, 5'd6, "sw_p");
    cycle(1'b0, 4'd4, 5'd2, 5'd6, 5'd0, "sw_c");
    if (FWD_EN) begin
      check("sw_c_stall_const", o_stall, 8'd0);
      nop("sw_e");
      nop("sw_m");
      check("sw_m_fwd_m_rt_const", o_fmrt, 8'd3);
    end
    nop("sw_f1"); nop("sw_f2"); nop("sw_f3");

    // ori writing $0 then a reader of $0
    cycle(1'b0, 4'd2, 5'd1, 5'd0, 5'd0, "z_p");
    cycle(1'b0, 4'd1, 5'd0, 5'd0, 5'd9, "z_c");
    check("z_c_stall_const", o_stall, 8'd0);
    check("z_c_fwd_d_rs_const", o_fdrs, 8'd0);
    nop("z_f1"); nop("z_f2");

    // reset in the middle of a load-use stall
    cycle(1'b0, 4'd3, 5'd1, 5'd0, 5'd5, "rs_p");
    cycle(1'b1, 4'd1, 5'd5, 5'd0, 5'd7, "rs_c");
    check("rs_c_stall_const", o_stall, 8'd1);
    nop("rs_after");
    check("rs_after_stall_const", o_stall, 8'd0);
    check("rs_after_fwd_e_rs_const", o_fers, 8'd0);

    // Random traffic; D held while the model says stall.
    ric = 4'd0; ra1 = 5'd0; ra2 = 5'd0; ra3 = 5'd0;
    for (int i = 0; i < 800; i++) begin
      rrst = ($urandom_range(0, 59) == 0);
      if (e_stall == 0 || reset) begin
        ric = 4'($urandom_range(0, 15));
        ra1 = 5'($urandom_range(0, 7));
        ra2 = 5'($urandom_range(0, 7));
        ra3 = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) ra3 = 5'd31;
      end
      cycle(rrst, ric, ra1, ra2, ra3, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
